// File: rtl/word_streamer.sv
// Serial-to-parallel word assembler feeding a show-ahead FIFO with valid/ready
// output handshake and a sticky overflow flag for dropped words.
module word_streamer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_enable,
  input  logic                         serial_in,
  input  logic                         frame_clear,
  input  logic                         clear_overflow,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic [$clog2(WIDTH)-1:0]     bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  logic [WIDTH-1:0]            asm_q, asm_next;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [FW-1:0]               fill_next;
  logic                        push, pop, full, write, drop;

  always_comb begin
    asm_next = (LSB_FIRST != 0) ? {serial_in, asm_q[WIDTH-1:1]}
                                : {asm_q[WIDTH-2:0], serial_in};
    push  = shift_enable && !frame_clear && (bit_count == LAST_BIT);
    pop   = out_valid && out_ready;
    full  = (fill_level == FULL_LVL);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    write = push && (!full || pop);
    drop  = push && full && !pop;
    fill_next = fill_level;
    case ({write, pop})
      2'b10:   fill_next = fill_level + FW'(1);
      2'b01:   fill_next = fill_level - FW'(1);
      default: fill_next = fill_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q      <= '0;
      bit_count  <= '0;
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (frame_clear) begin
        asm_q     <= '0;
        bit_count <= '0;
      end else if (shift_enable) begin
        asm_q     <= asm_next;
        bit_count <= push ? '0 : bit_count + CW'(1);
      end
      if (write) begin
        mem[wr_ptr] <= asm_next;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fill_level <= fill_next;
      out_valid  <= (fill_next != '0);
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Head entry read straight from storage; only registered pointers select it.
  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_word_streamer.sv
// Directed bench for word_streamer: MSB-first and LSB-first instances share
// stimulus and are checked against a queue-based scoreboard every cycle.
module tb_word_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1, se = 1'b0, sin = 1'b0, fc = 1'b0, co = 1'b0, rdy = 1'b0;
  logic [7:0] dm, dl;
  logic       vm, vl, om, ol;
  logic [2:0] fm, fl, bm, bl;

  logic [7:0] qm[$], ql[$];
  logic [7:0] am, al;
  int         cnt;
  logic       movf;
  int         passed = 0, total = 0;

  always #5 clk = ~clk;

  word_streamer #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .shift_enable(se), .serial_in(sin), .frame_clear(fc),
    .clear_overflow(co), .out_data(dm), .out_valid(vm), .out_ready(rdy),
    .overflow(om), .fill_level(fm), .bit_count(bm));

  word_streamer #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .shift_enable(se), .serial_in(sin), .frame_clear(fc),
    .clear_overflow(co), .out_data(dl), .out_valid(vl), .out_ready(rdy),
    .overflow(ol), .fill_level(fl), .bit_count(bl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a falling edge: check outputs, then advance one clock.
  task automatic step();
    logic p, push, drop;
    chk("valid_m", 32'(vm), 32'(qm.size() != 0));
    chk("valid_l", 32'(vl), 32'(ql.size() != 0));
    chk("fill_m",  32'(fm), 32'(qm.size()));
    chk("fill_l",  32'(fl), 32'(ql.size()));
    chk("ovf_m",   32'(om), 32'(movf));
    chk("ovf_l",   32'(ol), 32'(movf));
    chk("bcnt_m",  32'(bm), 32'(cnt));
    chk("bcnt_l",  32'(bl), 32'(cnt));
    p = !rst && rdy && (qm.size() > 0);
    if (p) begin
      chk("data_m", 32'(dm), 32'(qm[0]));
      chk("data_l", 32'(dl), 32'(ql[0]));
    end
    @(posedge clk);
    if (rst) begin
      qm.delete(); ql.delete();
      am = '0; al = '0; cnt = 0; movf = 1'b0;
    end else begin
      if (p) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      push = 1'b0;
      if (fc) begin
        cnt = 0; am = '0; al = '0;
      end else if (se) begin
        am = {am[6:0], sin};
        al = {sin, al[7:1]};
        if (cnt == 7) begin cnt = 0; push = 1'b1; end
        else cnt++;
      end
      drop = push && (qm.size() >= 4);
      if (push && !drop) begin
        qm.push_back(am);
        ql.push_back(al);
      end
      if (drop)    movf = 1'b1;
      else if (co) movf = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    se = 1'b1; sin = b;
    step();
    se = 1'b0; sin = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    am = '0; al = '0; cnt = 0; movf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(vm), 32'd0);
    chk("rst_data",  32'(dm), 32'd0);
    chk("rst_fill",  32'(fm), 32'd0);
    chk("rst_ovf",   32'(om), 32'd0);
    chk("rst_bcnt",  32'(bm), 32'd0);

    // Bit order: A5 is a palindrome, C0 reverses to 03
    send_word(8'hA5);
    chk("a5_valid", 32'(vm), 32'd1);
    chk("a5_msb",   32'(dm), 32'hA5);
    chk("a5_lsb",   32'(dl), 32'hA5);
    chk("a5_fill",  32'(fm), 32'd1);
    chk("a5_bcnt",  32'(bm), 32'd0);
    rdy = 1'b1; step(); rdy = 1'b0;
    send_word(8'hC0);
    chk("c0_msb", 32'(dm), 32'hC0);
    chk("c0_lsb", 32'(dl), 32'h03);
    rdy = 1'b1; step(); rdy = 1'b0;

    // Overflow on the fifth word, then drain
    for (int w = 1; w <= 5; w++) send_word(8'(w));
    chk("ovf_fill", 32'(fm), 32'd4);
    chk("ovf_set",  32'(om), 32'd1);
    chk("ovf_head", 32'(dm), 32'h01);
    rdy = 1'b1; idle(5); rdy = 1'b0;
    chk("drain_valid", 32'(vm), 32'd0);
    co = 1'b1; step(); co = 1'b0;
    chk("ovf_clr", 32'(om), 32'd0);

    // Full FIFO with a pop on the completing edge: no drop
    for (int w = 1; w <= 4; w++) send_word(8'(w));
    for (int i = 7; i >= 1; i--) send_bit(1'b0);
    rdy = 1'b1;
    send_bit(1'b1);
    chk("fullpop_fill", 32'(fm), 32'd4);
    chk("fullpop_ovf",  32'(om), 32'd0);
    chk("fullpop_head", 32'(dm), 32'h02);
    idle(5); rdy = 1'b0;
    chk("fullpop_empty", 32'(vm), 32'd0);

    // frame_clear with shift_enable discards the partial word; stall mid-word
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    se = 1'b1; fc = 1'b1; sin = 1'b1; step(); se = 1'b0; fc = 1'b0;
    chk("fc_bcnt", 32'(bm), 32'd0);
    send_bit(0); send_bit(0); send_bit(1); idle(3);
    send_bit(1); send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    chk("fc_fill", 32'(fm), 32'd1);
    chk("fc_msb",  32'(dm), 32'h3C);
    rdy = 1'b1; idle(2); rdy = 1'b0;
    chk("fc_one_word", 32'(fm), 32'd0);

    // Drop coinciding with clear_overflow: set wins
    for (int w = 0; w < 4; w++) send_word(8'h10 + 8'(w));
    for (int i = 7; i >= 1; i--) send_bit(1'b1);
    co = 1'b1; send_bit(1'b0); co = 1'b0;
    chk("setwins_ovf",  32'(om), 32'd1);
    chk("setwins_fill", 32'(fm), 32'd4);

    // Reset mid-word with words queued
    rdy = 1'b1; idle(2); rdy = 1'b0;
    send_bit(1); send_bit(0); send_bit(1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_valid", 32'(vm), 32'd0);
    chk("mrst_fill",  32'(fm), 32'd0);
    chk("mrst_bcnt",  32'(bm), 32'd0);
    chk("mrst_ovf",   32'(om), 32'd0);
    send_word(8'h35);
    chk("fresh_msb",  32'(dm), 32'h35);
    chk("fresh_lsb",  32'(dl), 32'hAC);
    chk("fresh_fill", 32'(fm), 32'd1);
    rdy = 1'b1; idle(2); rdy = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/word_streamer.md
# word_streamer

Parametrised serial-to-parallel deserialiser for the byte-streaming datapath. It replaces the fixed 8-bit, single-pulse byte streamer with three additions: configurable word width, selectable bit order, and a show-ahead output FIFO with a valid/ready handshake and sticky overflow reporting. It sits between a serial bit source (one bit per enabled cycle) and a word-oriented consumer that may stall.

## Interface
- WIDTH, 8, assembled word width in bits; 2..32.
- DEPTH, 4, output FIFO depth in words; power of 2, 2..16.
- LSB_FIRST, 0, bit order: 0 means first received bit lands in bit WIDTH-1 (MSB-first); 1 means first received bit lands in bit 0.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- shift_enable  input  1  qualifies serial_in for sampling this cycle.
- serial_in  input  1  serial data bit.
- frame_clear  input  1  discards the partially assembled word and restarts bit counting.
- clear_overflow  input  1  clears the sticky overflow flag.
- out_data  output  WIDTH  word at the FIFO head; valid only while out_valid=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when high together with out_valid.
- overflow  output  1  sticky; set when a completed word is dropped.
- fill_level  output  $clog2(DEPTH+1)  number of words in the FIFO.
- bit_count  output  $clog2(WIDTH)  number of bits of the current partial word received so far.

## Operation
- Assembly: on each edge with shift_enable=1 and frame_clear=0, serial_in is shifted into the assembly register and bit_count increments.
  - MSB-first: shift left, insert at bit 0.
  - LSB_FIRST=1: shift right, insert at bit WIDTH-1.
- Completion: when shift_enable=1 and bit_count==WIDTH-1:
  - The completed word, including the current bit, is pushed to the FIFO on the same edge.
  - bit_count returns to 0. The assembly register need not be cleared.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Show-ahead: out_data is always the head entry.
  - Pop occurs when out_valid and out_ready are both high.
- Full FIFO:
  - Push with no pop in the same cycle: the word is dropped, overflow is set to 1, and FIFO contents and fill_level are unchanged.
  - Push and pop in the same cycle: both succeed, fill_level is unchanged, and overflow is not set.
- Empty FIFO: out_ready is ignored and no pop occurs. A push to an empty FIFO is never bypassed to the output in the same cycle.
- frame_clear=1: bit_count becomes 0 and the assembly register becomes 0.
  - It takes priority over a simultaneous shift_enable: that bit is discarded and no push occurs, even when bit_count==WIDTH-1.
  - The FIFO, pops and overflow are unaffected.
- overflow: cleared by clear_overflow. If a drop coincides with clear_overflow, set wins and overflow stays 1.
- Reset (rst=1 at an edge) zeroes everything:
  - bit_count, the assembly register, both pointers and fill_level are 0.
  - out_valid=0, out_data=0, overflow=0.
  - Reset overrides all other inputs. Reset mid-word discards the partial word; reset with a non-empty FIFO discards its contents.

## Timing
- Latency from the edge that samples the final bit to out_valid=1: 1 cycle (visible after that edge) when the FIFO was empty.
- Throughput: one word per WIDTH enabled cycles in; one word per cycle out.
- Timing of fill_level and out_valid:
  - Both are registered and reflect every push and pop on the following cycle.
  - fill_level ranges 0..DEPTH.
  - out_valid equals (fill_level != 0).
- out_data changes only on a pop, or on a push into an empty FIFO.
- shift_enable may be deasserted for any number of cycles mid-word; partial state holds.
- No combinational path from out_ready to out_valid or out_data.

## Test plan
- WIDTH=8, MSB-first: shift in 1,0,1,0,0,1,0,1 on consecutive cycles with out_ready=0 -> out_valid=1 one cycle after the 8th bit, out_data=8'hA5, fill_level=1, bit_count=0.
- Same bit stream with LSB_FIRST=1 -> out_data=8'hA5 bit-reversed = 8'hA5 (palindrome). Repeat with stream 1,1,0,0,0,0,0,0 -> 8'h03, versus 8'hC0 for MSB-first.
- DEPTH=4, out_ready=0: send 5 words 8'h01..8'h05 -> fill_level=4, overflow=1 after the 5th; then drain with out_ready=1 -> outputs 01,02,03,04 on consecutive cycles, then out_valid=0.
- FIFO full with out_ready=1 on the same cycle the 5th word completes -> no overflow; drain order 01,02,03,04,05.
- Send 5 bits, assert frame_clear together with shift_enable, then send 8'h3C -> exactly one word out, 8'h3C. Assert clear_overflow in the same cycle as a drop -> overflow remains 1.
- Assert rst after 3 bits with 2 words queued -> next cycle out_valid=0, fill_level=0, bit_count=0, overflow=0. The next 8 bits form a fresh word.
